// File: rtl/dadda_operand_skid.sv
// dadda_operand_skid
//   Registered operand-issue stage feeding the 16x16 partial-product generator.
//   Operand pairs (a,b) arrive on a valid/ready handshake and sit in a two-entry
//   skid buffer (main + skid register). The main register drives out_a/out_b
//   directly, so the partial-product array always sees stable registered operands.
//   An issued-operation counter supports throughput checks.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       upstream pair valid
//   in_ready   out  1       registered; stage can accept a pair
//   in_a/in_b  in   WIDTH   multiplicand / multiplier
//   out_valid  out  1       registered pair valid toward the partial-product stage
//   out_ready  in   1       downstream accepts
//   out_a/b    out  WIDTH   main register contents
//   op_count   out  CNT_W   output handshakes since reset, wrapping
//   out_zero   out  1       present only with DADDA_ZERO_DETECT_EN defined:
//                           registered (out_a==0)|(out_b==0)
//
// Build option: define DADDA_ZERO_DETECT_EN to add the out_zero flag.

module dadda_operand_skid #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CNT_W-1:0] op_count
`ifdef DADDA_ZERO_DETECT_EN
  ,
  output logic             out_zero
`endif
);

  // state | meaning
  // EMPTY | main and skid empty
  // ONE   | main holds a pair, skid empty
  // FULL  | main and skid both hold a pair (in_ready low)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] skid_a;
  logic [WIDTH-1:0] skid_b;
  logic             acc;
  logic             iss;
  logic             load_main;
  logic             load_skid;
  logic [WIDTH-1:0] main_d_a;
  logic [WIDTH-1:0] main_d_b;

  assign acc = in_valid & in_ready;
  assign iss = out_valid & out_ready;

  // Next-state and datapath steering. The main register takes the incoming
  // pair except when draining FULL, where the skid entry moves up so order is kept.
  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    main_d_a   = in_a;
    main_d_b   = in_b;
    case (state)
      EMPTY: begin
        if (acc) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (acc && iss) begin
          load_main = 1'b1;
        end else if (acc) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (iss) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        main_d_a = skid_a;
        main_d_b = skid_b;
        if (iss) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      skid_a    <= '0;
      skid_b    <= '0;
      op_count  <= '0;
`ifdef DADDA_ZERO_DETECT_EN
      out_zero  <= 1'b1;
`endif
    end else begin
      state     <= next_state;
      // Registered from next_state so it never follows out_ready combinationally.
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
      if (iss) begin
        op_count <= op_count + 1'b1;
      end
      if (load_main) begin
        out_a <= main_d_a;
        out_b <= main_d_b;
`ifdef DADDA_ZERO_DETECT_EN
        out_zero <= (main_d_a == '0) | (main_d_b == '0);
`endif
      end
      if (load_skid) begin
        skid_a <= in_a;
        skid_b <= in_b;
      end
    end
  end

endmodule

// File: tb/tb_dadda_operand_skid.sv
module tb_dadda_operand_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;

  logic        in_ready,  in_ready_w;
  logic        out_valid, out_valid_w;
  logic [15:0] out_a, out_b, out_a_w, out_b_w;
  logic [15:0] op_count;
  logic [3:0]  op_count_w;
`ifdef DADDA_ZERO_DETECT_EN
  logic        out_zero, out_zero_w;
`endif

  always #5 clk = ~clk;

  dadda_operand_skid #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .op_count(op_count)
`ifdef DADDA_ZERO_DETECT_EN
    , .out_zero(out_zero)
`endif
  );

  // Narrow-counter instance sharing the same stimulus, for wrap checking.
  dadda_operand_skid #(.WIDTH(16), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_a(out_a_w), .out_b(out_b_w), .op_count(op_count_w)
`ifdef DADDA_ZERO_DETECT_EN
    , .out_zero(out_zero_w)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of accepted pairs, capacity two. Whatever sits at
  // the head is what the outputs must show; occupancy decides valid/ready.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  pair_t       q[$];
  int          cnt       = 0;
  logic [15:0] last_a    = '0;
  logic [15:0] last_b    = '0;
  logic        last_zero = 1'b1;
  logic        prev_rst  = 1'b1;

  always @(negedge clk) begin
    logic  exp_ready;
    logic  exp_valid;
    pair_t p;
    exp_ready = !prev_rst && (q.size() < 2);
    exp_valid = (q.size() != 0);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("op_count", 32'(op_count), 32'(cnt % 65536));
    chk("op_count_w", 32'(op_count_w), 32'(cnt % 16));
    chk("out_valid_w", 32'(out_valid_w), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_a", 32'(out_a), 32'(q[0].a));
      chk("out_b", 32'(out_b), 32'(q[0].b));
    end else begin
      chk("out_a_hold", 32'(out_a), 32'(last_a));
      chk("out_b_hold", 32'(out_b), 32'(last_b));
    end
`ifdef DADDA_ZERO_DETECT_EN
    chk("out_zero", 32'(out_zero),
        exp_valid ? 32'((q[0].a == 16'h0) || (q[0].b == 16'h0)) : 32'(last_zero));
`endif
    // Inputs are driven just after posedge, so values here are what the next edge sees.
    if (rst) begin
      q.delete();
      cnt       = 0;
      last_a    = '0;
      last_b    = '0;
      last_zero = 1'b1;
      prev_rst  = 1'b1;
    end else begin
      prev_rst = 1'b0;
      if (exp_valid && out_ready) begin
        p         = q.pop_front();
        last_a    = p.a;
        last_b    = p.b;
        last_zero = (p.a == 16'h0) || (p.b == 16'h0);
        cnt++;
      end
      if (exp_ready && in_valid) begin
        p.a = in_a;
        p.b = in_b;
        q.push_back(p);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      errors++;
      $display("FAIL send_timeout actual=no_accept expected=accept t=%0t", $time);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // single operation
    out_ready = 1'b1;
    send(16'h00FF, 16'h0003);
    in_valid = 1'b0;
    idle(3);

    // backpressure into FULL, then release
    out_ready = 1'b0;
    send(16'd1, 16'd2);
    send(16'd3, 16'd4);
    in_valid = 1'b0;
    idle(4);
    out_ready = 1'b1;
    idle(4);

    // streaming 100 back-to-back pairs
    for (int i = 0; i < 100; i++) send(16'($urandom), 16'($urandom));
    in_valid = 1'b0;
    idle(3);

    // zero-detect patterns
    send(16'h0000, 16'hFFFF);
    send(16'h8001, 16'h0002);
    in_valid = 1'b0;
    idle(3);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // reset while FULL discards both pairs
    out_ready = 1'b0;
    send(16'hAAAA, 16'h5555);
    send(16'h1234, 16'h4321);
    in_valid = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(2);

    // 17 issues: the 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) send(16'(i + 1), 16'(i + 7));
    in_valid = 1'b0;
    idle(3);
    chk("wrap_op_count_w", 32'(op_count_w), 32'd1);
    chk("wrap_op_count", 32'(op_count), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
